// File: rtl/select_decode_32_if.sv
// Select/decode bus between the control unit (master) and the decode unit (slave).
//   master drives: ir_load, ir_in, sel_valid, gra/grb/grc, r_in, r_out, ba_out, err_clr
//   slave drives:  r_in_en, r_out_en, ba_zero, sel_idx, c_sext, dec_valid, sel_err
interface select_decode_32_if;
  localparam int unsigned IR_WIDTH = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned IDX_W    = 5;

  logic                ir_load;
  logic [IR_WIDTH-1:0] ir_in;
  logic                sel_valid;
  logic                gra;
  logic                grb;
  logic                grc;
  logic                r_in;
  logic                r_out;
  logic                ba_out;
  logic                err_clr;

  logic [NREG-1:0]     r_in_en;
  logic [NREG-1:0]     r_out_en;
  logic                ba_zero;
  logic [IDX_W-1:0]    sel_idx;
  logic [IR_WIDTH-1:0] c_sext;
  logic                dec_valid;
  logic                sel_err;

  modport master (
    output ir_load, ir_in, sel_valid, gra, grb, grc, r_in, r_out, ba_out, err_clr,
    input  r_in_en, r_out_en, ba_zero, sel_idx, c_sext, dec_valid, sel_err
  );

  modport slave (
    input  ir_load, ir_in, sel_valid, gra, grb, grc, r_in, r_out, ba_out, err_clr,
    output r_in_en, r_out_en, ba_zero, sel_idx, c_sext, dec_valid, sel_err
  );
endinterface

// File: rtl/select_decode_32.sv
// Registered select-and-decode unit. Latches the instruction register, picks the
// ra/rb/rc field under the gra/grb/grc strobes and decodes it to one-hot register
// file enables one cycle later.
//   clk  : rising-edge clock
//   clr  : asynchronous active-high reset
//   bus  : select_decode_32_if.slave (request inputs, decoded enables, c_sext, sel_err)
module select_decode_32 #(
  parameter int unsigned REG_COUNT = 16
) (
  input logic              clk,
  input logic              clr,
  select_decode_32_if.slave bus
);
  localparam int unsigned IR_WIDTH = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned FLD_W    = 4;
  localparam int unsigned C_W      = 19;

  logic [IR_WIDTH-1:0] ir;
  logic [FLD_W-1:0]    fld_c;
  logic [IDX_W-1:0]    idx_c;
  logic                strobe_ok_c;
  logic                legal_c;
  logic                ba0_c;
  logic [NREG-1:0]     onehot_c;
  logic [NREG-1:0]     r_in_en_d;
  logic [NREG-1:0]     r_out_en_d;
  logic                ba_zero_d;

  logic [NREG-1:0]     r_in_en_q;
  logic [NREG-1:0]     r_out_en_q;
  logic                ba_zero_q;
  logic [IDX_W-1:0]    sel_idx_q;
  logic                dec_valid_q;
  logic                sel_err_q;

  // Field select, legality and one-hot decode of the current request.
  always_comb begin
    fld_c       = ir[18:15];
    if (bus.gra)      fld_c = ir[26:23];
    else if (bus.grb) fld_c = ir[22:19];
    strobe_ok_c = ({bus.gra, bus.grb, bus.grc} == 3'b100) ||
                  ({bus.gra, bus.grb, bus.grc} == 3'b010) ||
                  ({bus.gra, bus.grb, bus.grc} == 3'b001);
    idx_c       = {1'b0, fld_c};
    legal_c     = strobe_ok_c && (32'(idx_c) < REG_COUNT);
    onehot_c    = NREG'(1) << idx_c;
    ba0_c       = bus.ba_out && (idx_c == '0);

    r_in_en_d   = '0;
    r_out_en_d  = '0;
    ba_zero_d   = 1'b0;
    if (bus.sel_valid && legal_c) begin
      if (bus.r_in) r_in_en_d = onehot_c;
      // Base-address read of R0 puts a constant zero on the bus instead of R0.
      if (ba0_c)                         ba_zero_d  = 1'b1;
      else if (bus.r_out || bus.ba_out)  r_out_en_d = onehot_c;
    end
  end

  // Instruction register; a same-edge load only affects later requests.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) ir <= '0;
    else if (bus.ir_load) ir <= bus.ir_in;
  end

  // Decode output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_in_en_q   <= '0;
      r_out_en_q  <= '0;
      ba_zero_q   <= 1'b0;
      sel_idx_q   <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      r_in_en_q   <= r_in_en_d;
      r_out_en_q  <= r_out_en_d;
      ba_zero_q   <= ba_zero_d;
      dec_valid_q <= bus.sel_valid;
      if (bus.sel_valid) sel_idx_q <= idx_c;
    end
  end

  // Sticky error; a new illegal select outranks err_clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                             sel_err_q <= 1'b0;
    else if (bus.sel_valid && !legal_c)  sel_err_q <= 1'b1;
    else if (bus.err_clr)                sel_err_q <= 1'b0;
  end

  assign bus.r_in_en   = r_in_en_q;
  assign bus.r_out_en  = r_out_en_q;
  assign bus.ba_zero   = ba_zero_q;
  assign bus.sel_idx   = sel_idx_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.c_sext    = {{(IR_WIDTH-C_W){ir[C_W-1]}}, ir[C_W-1:0]};

  // Opcode bits are not used by this block.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir[IR_WIDTH-1:27];
endmodule

// File: tb/tb_select_decode_32.sv
module tb_select_decode_32;
  localparam int unsigned REG_COUNT = 16;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  select_decode_32_if bus();
  select_decode_32 #(.REG_COUNT(REG_COUNT)) dut (.clk(clk), .clr(clr), .bus(bus));

  typedef struct {
    logic [31:0] rin;
    logic [31:0] rout;
    logic        baz;
    logic [4:0]  idx;
    logic        dv;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_ir;
  logic        m_err;
  logic [4:0]  m_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference bus-select encoder: one-hot to index.
  function automatic logic [4:0] enc(input logic [31:0] v);
    enc = '0;
    for (int i = 0; i < 32; i++) if (v[i]) enc = 5'(i);
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_rin"},  bus.r_in_en,  e.rin);
    check({tag, "_rout"}, bus.r_out_en, e.rout);
    check({tag, "_baz"},  32'(bus.ba_zero),   32'(e.baz));
    check({tag, "_idx"},  32'(bus.sel_idx),   32'(e.idx));
    check({tag, "_dv"},   32'(bus.dec_valid), 32'(e.dv));
    check({tag, "_err"},  32'(bus.sel_err),   32'(e.err));
    check({tag, "_onehot"}, 32'($countones(bus.r_out_en) <= 1), 32'd1);
    if (e.rout != 0) check({tag, "_enc"}, 32'(enc(bus.r_out_en)), 32'(e.idx));
  endtask

  // Drive one cycle of stimulus at negedge, push the model's expectation, compare after the edge.
  task automatic drive(input string tag, input logic sv, input logic [2:0] g, input logic ri,
                       input logic ro, input logic ba, input logic ec, input logic il,
                       input logic [31:0] iw);
    exp_t       e;
    logic [4:0] idx;
    logic       legal;
    @(negedge clk);
    bus.sel_valid = sv;
    bus.gra = g[2]; bus.grb = g[1]; bus.grc = g[0];
    bus.r_in = ri; bus.r_out = ro; bus.ba_out = ba; bus.err_clr = ec;
    bus.ir_load = il; bus.ir_in = iw;
    if (g[2])      idx = {1'b0, m_ir[26:23]};
    else if (g[1]) idx = {1'b0, m_ir[22:19]};
    else           idx = {1'b0, m_ir[18:15]};
    legal  = ($countones(g) == 1) && (32'(idx) < REG_COUNT);
    e.rin  = '0;
    e.rout = '0;
    e.baz  = 1'b0;
    e.dv   = sv;
    if (sv) begin
      m_idx = idx;
      if (legal) begin
        if (ri) e.rin = 32'd1 << idx;
        if (ba && idx == 5'd0) e.baz = 1'b1;
        else if (ro || ba)     e.rout = 32'd1 << idx;
      end
    end
    if (sv && !legal) m_err = 1'b1;
    else if (ec)      m_err = 1'b0;
    e.idx = m_idx;
    e.err = m_err;
    sb.push_back(e);
    if (il) m_ir = iw;
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic idle_inputs();
    bus.ir_load = 0; bus.ir_in = '0; bus.sel_valid = 0;
    bus.gra = 0; bus.grb = 0; bus.grc = 0;
    bus.r_in = 0; bus.r_out = 0; bus.ba_out = 0; bus.err_clr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    clr   = 1'b1;
    m_ir  = '0;
    m_err = 1'b0;
    m_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rin",    bus.r_in_en,  32'd0);
    check("reset_rout",   bus.r_out_en, 32'd0);
    check("reset_dv",     32'(bus.dec_valid), 32'd0);
    check("reset_err",    32'(bus.sel_err),   32'd0);
    check("reset_csext",  bus.c_sext,   32'd0);
    @(negedge clk);
    clr = 1'b0;

    // Reset mid-request: outputs clear immediately, in-flight request dropped.
    drive("ld1", 0, 3'b000, 0, 0, 0, 0, 1, 32'h01880000);
    drive("pre_clr", 1, 3'b100, 0, 1, 0, 0, 0, '0);
    @(negedge clk);
    bus.sel_valid = 1; bus.gra = 1; bus.r_out = 1;
    #1 clr = 1'b1;
    #1;
    check("clr_now_dv",   32'(bus.dec_valid), 32'd0);
    check("clr_now_rout", bus.r_out_en, 32'd0);
    check("clr_now_idx",  32'(bus.sel_idx), 32'd0);
    @(posedge clk);
    #1;
    check("clr_edge_dv",  32'(bus.dec_valid), 32'd0);
    clr = 1'b0;
    idle_inputs();
    m_ir = '0; m_err = 1'b0; m_idx = '0;
    sb.delete();
    @(posedge clk);
    #1;
    check("clr_after_dv", 32'(bus.dec_valid), 32'd0);

    // ra=3, rb=1 decode.
    drive("ld2",   0, 3'b000, 0, 0, 0, 0, 1, 32'h01880000);
    drive("ra_out", 1, 3'b100, 0, 1, 0, 0, 0, '0);
    drive("rb_ba",  1, 3'b010, 0, 0, 1, 0, 0, '0);
    drive("both",   1, 3'b100, 1, 1, 0, 0, 0, '0);
    drive("noreq",  0, 3'b100, 1, 1, 0, 0, 0, '0);
    // ra=0 base-address read gives ba_zero.
    drive("ld3",   0, 3'b000, 0, 0, 0, 0, 1, 32'h00080000);
    drive("ba_r0",  1, 3'b100, 0, 0, 1, 0, 0, '0);
    drive("ba_r0o", 1, 3'b100, 1, 1, 1, 0, 0, '0);
    drive("rb_ba1", 1, 3'b010, 0, 0, 1, 0, 0, '0);

    // Sweep rc 0..15 back-to-back, loading the next IR on the same edge.
    drive("ld_sw", 0, 3'b000, 0, 0, 0, 0, 1, 32'h00000000);
    for (int i = 0; i < 16; i++)
      drive($sformatf("sweep%0d", i), 1, 3'b001, 1, (i % 2) == 1, 0, 0, 1, 32'(i + 1) << 15);

    // Illegal selects and sticky error.
    drive("ld5",   0, 3'b000, 0, 0, 0, 0, 1, 32'h01880000);
    drive("ill_ab", 1, 3'b110, 1, 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive($sformatf("hold%0d", i), 0, 3'b000, 0, 0, 0, 0, 0, '0);
    drive("errclr", 0, 3'b000, 0, 0, 0, 1, 0, '0);
    drive("ill_0",  1, 3'b000, 1, 1, 0, 0, 0, '0);
    drive("errclr2", 0, 3'b000, 0, 0, 0, 1, 0, '0);
    drive("ill_set_clr", 1, 3'b011, 0, 1, 0, 1, 0, '0);
    drive("errclr3", 0, 3'b000, 0, 0, 0, 1, 0, '0);

    // Sign extension of the constant field.
    drive("ld_neg", 0, 3'b000, 0, 0, 0, 0, 1, 32'h00040000);
    check("csext_neg", bus.c_sext, 32'hFFFC0000);
    drive("ld_pos", 0, 3'b000, 0, 0, 0, 0, 1, 32'h0000001F);
    check("csext_pos", bus.c_sext, 32'h0000001F);

    // Same-edge load and request: old IR field decoded.
    drive("ld_ra5", 0, 3'b000, 0, 0, 0, 0, 1, 32'h02800000);
    drive("old_ir", 1, 3'b100, 0, 1, 0, 0, 1, 32'h04800000);
    drive("new_ir", 1, 3'b100, 0, 1, 0, 0, 0, '0);
    drive("tail",   0, 3'b000, 0, 0, 0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
